// File: rtl/refresh_scheduler_pkg.sv
// Shared definitions for the gain-cell refresh scheduler.
//   ref_state_e      : scheduler FSM states (IDLE / REFRESH / FORCE)
//   ROW_W            : row address width (128 rows -> 7 bits)
//   DEF_ROWS         : default rows per bank
//   DEF_REF_INTERVAL : default cycles between refresh-burst requests
package refresh_scheduler_pkg;

  localparam int ROW_W            = 7;
  localparam int DEF_ROWS         = 128;
  localparam int DEF_REF_INTERVAL = 1024;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_REFRESH = 2'd1,
    ST_FORCE   = 2'd2
  } ref_state_e;

endpackage

// File: rtl/refresh_scheduler_timer.sv
// refresh_timer: interval down-counter that raises a refresh request.
// Ports:
//   clk, rst_n : clock, asynchronous active-low reset
//   enable_i   : counter runs only while high, otherwise holds
//   busy_i     : a burst is in progress (expiry now counts as overrun)
//   clear_i    : the scheduler accepted the pending request this cycle
//   pending_o  : one outstanding burst request (never queues more than one)
//   overrun_o  : sticky, an interval expired while a request was still
//                pending or a burst was still running
module refresh_timer
  import refresh_scheduler_pkg::*;
#(
  parameter int REF_INTERVAL = DEF_REF_INTERVAL
) (
  input  logic clk,
  input  logic rst_n,
  input  logic enable_i,
  input  logic busy_i,
  input  logic clear_i,
  output logic pending_o,
  output logic overrun_o
);

  localparam int               CNT_W  = (REF_INTERVAL > 1) ? $clog2(REF_INTERVAL) : 1;
  localparam logic [CNT_W-1:0] RELOAD = CNT_W'(REF_INTERVAL - 1);

  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             pending_q, pending_d;
  logic             overrun_q, overrun_d;
  logic             expire;

  always_comb begin
    expire    = enable_i && (cnt_q == '0);
    cnt_d     = cnt_q;
    pending_d = pending_q;
    if (enable_i) begin
      cnt_d = expire ? RELOAD : cnt_q - 1'b1;
    end
    if (clear_i) begin
      pending_d = 1'b0;
    end
    // A fresh expiry wins over an acceptance in the same cycle.
    if (expire) begin
      pending_d = 1'b1;
    end
    overrun_d = overrun_q | (expire & (pending_q | busy_i));
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q     <= RELOAD;
      pending_q <= 1'b0;
      overrun_q <= 1'b0;
    end else begin
      cnt_q     <= cnt_d;
      pending_q <= pending_d;
      overrun_q <= overrun_d;
    end
  end

  assign pending_o = pending_q;
  assign overrun_o = overrun_q;

endmodule

// File: rtl/refresh_scheduler.sv
// refresh_scheduler: sequences row refresh bursts over NUM_BANKS gain-cell
// banks, yielding to user accesses on the bank being refreshed until
// MAX_DEFER consecutive deferrals, then forcing the burst and stalling users
// of that bank only.
// Ports:
//   clk, rst_n          : clock, asynchronous active-low reset
//   ref_enable          : global enable; low freezes timer and FSM
//   u_re, u_we, u_bank  : user access strobes and target bank
//   ref_en_current      : one-hot bank refreshed this cycle (or zero)
//   ref_en_old          : ref_en_current one cycle later (write-back)
//   sr_addr/sr_addr_old : row read this cycle / one cycle ago
//   sr_indicator_old    : the row in sr_addr_old was really read
//   u_stall             : user must hold its access (FORCE, same bank)
//   ref_busy, ref_done  : burst in progress / one-cycle end-of-burst pulse
//   overrun             : sticky, refresh requests arrived too fast
//   dbg_state_o         : current FSM state
module refresh_scheduler
  import refresh_scheduler_pkg::*;
#(
  parameter int NUM_BANKS    = 4,
  parameter int ROWS         = DEF_ROWS,
  parameter int REF_INTERVAL = DEF_REF_INTERVAL,
  parameter int MAX_DEFER    = 8
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic                         ref_enable,
  input  logic                         u_re,
  input  logic                         u_we,
  input  logic [$clog2(NUM_BANKS)-1:0] u_bank,
  output logic [NUM_BANKS-1:0]         ref_en_current,
  output logic [NUM_BANKS-1:0]         ref_en_old,
  output logic [ROW_W-1:0]             sr_addr,
  output logic [ROW_W-1:0]             sr_addr_old,
  output logic                         sr_indicator_old,
  output logic                         u_stall,
  output logic                         ref_busy,
  output logic                         ref_done,
  output logic                         overrun,
  output logic [1:0]                   dbg_state_o
);

  localparam int                 BANK_W     = $clog2(NUM_BANKS);
  localparam int                 DEFER_W    = $clog2(MAX_DEFER + 1);
  localparam logic [ROW_W-1:0]   LAST_ROW   = ROW_W'(ROWS - 1);
  localparam logic [DEFER_W-1:0] DEFER_LAST = DEFER_W'(MAX_DEFER - 1);

  ref_state_e           state_q;
  logic [BANK_W-1:0]    bank_ptr_q;
  logic [ROW_W-1:0]     sr_addr_q;
  logic [DEFER_W-1:0]   defer_q;
  logic [NUM_BANKS-1:0] ref_en_old_q;
  logic [ROW_W-1:0]     sr_addr_old_q;
  logic                 sr_ind_old_q;
  logic                 done_q;

  logic pending;
  logic start;
  logic collision;
  logic refreshing;

  assign collision  = (u_re | u_we) && (u_bank == bank_ptr_q);
  assign start      = ref_enable && (state_q == ST_IDLE) && pending;
  // A row is actually read this cycle: always in FORCE, in REFRESH only
  // when the user is not touching the same bank.
  assign refreshing = ref_enable &&
                      ((state_q == ST_FORCE) || ((state_q == ST_REFRESH) && !collision));

  refresh_timer #(
    .REF_INTERVAL(REF_INTERVAL)
  ) u_timer (
    .clk      (clk),
    .rst_n    (rst_n),
    .enable_i (ref_enable),
    .busy_i   (ref_busy),
    .clear_i  (start),
    .pending_o(pending),
    .overrun_o(overrun)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q       <= ST_IDLE;
      bank_ptr_q    <= '0;
      sr_addr_q     <= '0;
      defer_q       <= '0;
      ref_en_old_q  <= '0;
      sr_addr_old_q <= '0;
      sr_ind_old_q  <= 1'b0;
      done_q        <= 1'b0;
    end else begin
      ref_en_old_q  <= ref_en_current;
      sr_addr_old_q <= sr_addr_q;
      sr_ind_old_q  <= |ref_en_current;
      done_q        <= 1'b0;
      if (ref_enable) begin
        case (state_q)
          ST_IDLE: begin
            if (pending) begin
              state_q   <= ST_REFRESH;
              sr_addr_q <= '0;
              defer_q   <= '0;
            end
          end
          ST_REFRESH: begin
            if (collision) begin
              defer_q <= defer_q + 1'b1;
              if (defer_q == DEFER_LAST) begin
                state_q <= ST_FORCE;
              end
            end else begin
              defer_q <= '0;
            end
          end
          ST_FORCE: begin
          end
          default: state_q <= ST_IDLE;
        endcase
        // Row advance and burst end; overrides the case above on the last row.
        if (refreshing) begin
          if (sr_addr_q == LAST_ROW) begin
            sr_addr_q  <= '0;
            bank_ptr_q <= bank_ptr_q + 1'b1;
            state_q    <= ST_IDLE;
            defer_q    <= '0;
            done_q     <= 1'b1;
          end else begin
            sr_addr_q <= sr_addr_q + 1'b1;
          end
        end
      end
    end
  end

  assign ref_en_current   = refreshing ? (NUM_BANKS'(1) << bank_ptr_q) : '0;
  assign ref_en_old       = ref_en_old_q;
  assign sr_addr          = sr_addr_q;
  assign sr_addr_old      = sr_addr_old_q;
  assign sr_indicator_old = sr_ind_old_q;
  assign u_stall          = ref_enable && (state_q == ST_FORCE) && collision;
  assign ref_busy         = (state_q != ST_IDLE);
  assign ref_done         = done_q;
  assign dbg_state_o      = state_q;

endmodule

// File: tb/tb_refresh_scheduler.sv
module tb_refresh_scheduler;
  import refresh_scheduler_pkg::*;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst_n;
  logic       ref_enable;
  logic       u_re;
  logic       u_we;
  logic [1:0] u_bank;

  logic [3:0] ref_en_a, ref_en_old_a, ref_en_b, ref_en_old_b;
  logic [6:0] sr_addr_a, sr_addr_old_a, sr_addr_b, sr_addr_old_b;
  logic       ind_a, stall_a, busy_a, done_a, overrun_a;
  logic       ind_b, stall_b, busy_b, done_b, overrun_b;
  logic [1:0] dbg_a, dbg_b;

  int checks = 0;
  int errors = 0;
  int edge_n = 0;

  refresh_scheduler #(.NUM_BANKS(4), .ROWS(128), .REF_INTERVAL(16), .MAX_DEFER(8)) dut_a (
    .clk(clk), .rst_n(rst_n), .ref_enable(ref_enable), .u_re(u_re), .u_we(u_we), .u_bank(u_bank),
    .ref_en_current(ref_en_a), .ref_en_old(ref_en_old_a), .sr_addr(sr_addr_a),
    .sr_addr_old(sr_addr_old_a), .sr_indicator_old(ind_a), .u_stall(stall_a),
    .ref_busy(busy_a), .ref_done(done_a), .overrun(overrun_a), .dbg_state_o(dbg_a)
  );

  refresh_scheduler #(.NUM_BANKS(4), .ROWS(128), .REF_INTERVAL(64), .MAX_DEFER(8)) dut_b (
    .clk(clk), .rst_n(rst_n), .ref_enable(ref_enable), .u_re(u_re), .u_we(u_we), .u_bank(u_bank),
    .ref_en_current(ref_en_b), .ref_en_old(ref_en_old_b), .sr_addr(sr_addr_b),
    .sr_addr_old(sr_addr_old_b), .sr_indicator_old(ind_b), .u_stall(stall_b),
    .ref_busy(busy_b), .ref_done(done_b), .overrun(overrun_b), .dbg_state_o(dbg_b)
  );

  // ---------------- driver tasks ----------------
  // Cycle c spans rising edge c to edge c+1; inputs are driven just after
  // edge c and outputs are sampled on the following falling edge.
  task automatic next_edge();
    @(posedge clk);
    #1;
    edge_n++;
  endtask

  task automatic idle_inputs();
    ref_enable = 1'b1;
    u_re       = 1'b0;
    u_we       = 1'b0;
    u_bank     = 2'd0;
  endtask

  task automatic apply_reset();
    rst_n = 1'b0;
    idle_inputs();
    repeat (3) @(posedge clk);
    #1;
    rst_n  = 1'b1;
    edge_n = 0;
  endtask

  // Expected refresh pattern of the REF_INTERVAL=16 instance without traffic:
  // burst k occupies cycles 17+129k .. 144+129k, then one IDLE cycle.
  function automatic logic [3:0] model_en(input int c);
    int k, off;
    if (c < 17) return 4'b0000;
    k   = (c - 17) / 129;
    off = (c - 17) % 129;
    return (off < 128) ? 4'(1 << (k % 4)) : 4'b0000;
  endfunction

  function automatic logic [6:0] model_addr(input int c);
    int off;
    if (c < 17) return 7'd0;
    off = (c - 17) % 129;
    return (off < 128) ? 7'(off) : 7'd0;
  endfunction

  // ---------------- scenarios ----------------
  task automatic test_reset();
    rst_n = 1'b0;
    idle_inputs();
    #23;
    checks++; if (ref_en_a !== 4'b0) begin errors++; $display("FAIL reset_ref_en actual=%b required=0000", ref_en_a); end
    checks++; if (ref_en_old_a !== 4'b0) begin errors++; $display("FAIL reset_ref_en_old actual=%b required=0000", ref_en_old_a); end
    checks++; if (sr_addr_a !== 7'd0) begin errors++; $display("FAIL reset_sr_addr actual=%0d required=0", sr_addr_a); end
    checks++; if (sr_addr_old_a !== 7'd0) begin errors++; $display("FAIL reset_sr_addr_old actual=%0d required=0", sr_addr_old_a); end
    checks++; if (ind_a !== 1'b0) begin errors++; $display("FAIL reset_indicator actual=%b required=0", ind_a); end
    checks++; if (stall_a !== 1'b0) begin errors++; $display("FAIL reset_stall actual=%b required=0", stall_a); end
    checks++; if (busy_a !== 1'b0) begin errors++; $display("FAIL reset_busy actual=%b required=0", busy_a); end
    checks++; if (done_a !== 1'b0) begin errors++; $display("FAIL reset_done actual=%b required=0", done_a); end
    checks++; if (overrun_a !== 1'b0) begin errors++; $display("FAIL reset_overrun actual=%b required=0", overrun_a); end
    checks++; if (dbg_a !== 2'(ST_IDLE)) begin errors++; $display("FAIL reset_state actual=%0d required=0", dbg_a); end
  endtask

  task automatic test_first_burst();
    logic [3:0] exp_en;
    logic [6:0] exp_addr;
    apply_reset();
    for (int c = 1; c <= 146; c++) begin
      next_edge();
      @(negedge clk);
      exp_en   = (c >= 17 && c <= 144) ? 4'b0001 : ((c == 146) ? 4'b0010 : 4'b0000);
      exp_addr = (c >= 17 && c <= 144) ? 7'(c - 17) : 7'd0;
      checks++; if (ref_en_a !== exp_en) begin errors++; $display("FAIL first_en cycle=%0d actual=%b required=%b", c, ref_en_a, exp_en); end
      checks++; if (sr_addr_a !== exp_addr) begin errors++; $display("FAIL first_addr cycle=%0d actual=%0d required=%0d", c, sr_addr_a, exp_addr); end
      checks++; if (done_a !== (c == 145)) begin errors++; $display("FAIL first_done cycle=%0d actual=%b", c, done_a); end
      checks++; if (busy_a !== (c >= 17 && c <= 144 || c == 146)) begin errors++; $display("FAIL first_busy cycle=%0d actual=%b", c, busy_a); end
      if (c == 31 || c == 32 || c == 146) begin
        checks++; if (overrun_a !== (c >= 32)) begin errors++; $display("FAIL overrun16 cycle=%0d actual=%b", c, overrun_a); end
      end
      if (c == 127 || c == 128 || c == 146) begin
        checks++; if (overrun_b !== (c >= 128)) begin errors++; $display("FAIL overrun64 cycle=%0d actual=%b", c, overrun_b); end
      end
      if (c == 145) begin
        checks++; if (ref_en_old_a !== 4'b0001) begin errors++; $display("FAIL wb_en_old actual=%b required=0001", ref_en_old_a); end
        checks++; if (sr_addr_old_a !== 7'd127) begin errors++; $display("FAIL wb_addr_old actual=%0d required=127", sr_addr_old_a); end
        checks++; if (ind_a !== 1'b1) begin errors++; $display("FAIL wb_indicator actual=%b required=1", ind_a); end
      end
    end
  endtask

  task automatic test_collision();
    logic [6:0] exp_addr;
    logic [3:0] exp_en;
    logic       exp_ind;
    apply_reset();
    for (int c = 1; c <= 27; c++) begin
      next_edge();
      u_re   = (c >= 22 && c <= 24);
      u_we   = (c == 26 || c == 27);
      u_bank = (c >= 26) ? 2'd1 : 2'd0;
      @(negedge clk);
      if (c >= 17) begin
        exp_addr = (c <= 22) ? 7'(c - 17) : ((c <= 25) ? 7'd5 : 7'(c - 20));
        exp_en   = (c >= 22 && c <= 24) ? 4'b0000 : 4'b0001;
        exp_ind  = (c >= 18) && !(c >= 23 && c <= 25);
        checks++; if (sr_addr_a !== exp_addr) begin errors++; $display("FAIL coll_addr cycle=%0d actual=%0d required=%0d", c, sr_addr_a, exp_addr); end
        checks++; if (ref_en_a !== exp_en) begin errors++; $display("FAIL coll_en cycle=%0d actual=%b required=%b", c, ref_en_a, exp_en); end
        checks++; if (ind_a !== exp_ind) begin errors++; $display("FAIL coll_indicator cycle=%0d actual=%b required=%b", c, ind_a, exp_ind); end
        checks++; if (dbg_a !== 2'(ST_REFRESH)) begin errors++; $display("FAIL coll_state cycle=%0d actual=%0d required=1", c, dbg_a); end
        checks++; if (stall_a !== 1'b0) begin errors++; $display("FAIL coll_stall cycle=%0d actual=%b required=0", c, stall_a); end
      end
    end
  endtask

  task automatic test_force();
    logic [1:0] exp_st;
    logic [6:0] exp_addr;
    logic [3:0] exp_en;
    logic       exp_stall;
    apply_reset();
    for (int c = 1; c <= 154; c++) begin
      next_edge();
      u_re   = (c >= 17 && c <= 26) || (c >= 152);
      u_we   = (c == 27);
      u_bank = (c == 26) ? 2'd1 : 2'd0;
      @(negedge clk);
      if (c >= 17) begin
        exp_st    = (c <= 24) ? 2'(ST_REFRESH) : (c <= 152) ? 2'(ST_FORCE) : (c == 153) ? 2'(ST_IDLE) : 2'(ST_REFRESH);
        exp_addr  = (c >= 25 && c <= 152) ? 7'(c - 25) : 7'd0;
        exp_en    = (c >= 25 && c <= 152) ? 4'b0001 : ((c == 154) ? 4'b0010 : 4'b0000);
        exp_stall = (c == 25 || c == 27 || c == 152);
        checks++; if (dbg_a !== exp_st) begin errors++; $display("FAIL force_state cycle=%0d actual=%0d required=%0d", c, dbg_a, exp_st); end
        checks++; if (sr_addr_a !== exp_addr) begin errors++; $display("FAIL force_addr cycle=%0d actual=%0d required=%0d", c, sr_addr_a, exp_addr); end
        checks++; if (ref_en_a !== exp_en) begin errors++; $display("FAIL force_en cycle=%0d actual=%b required=%b", c, ref_en_a, exp_en); end
        checks++; if (stall_a !== exp_stall) begin errors++; $display("FAIL force_stall cycle=%0d actual=%b required=%b", c, stall_a, exp_stall); end
        checks++; if (done_a !== (c == 153)) begin errors++; $display("FAIL force_done cycle=%0d actual=%b", c, done_a); end
      end
    end
    idle_inputs();
  endtask

  task automatic test_enable();
    logic [6:0] exp_addr;
    logic [3:0] exp_en;
    apply_reset();
    for (int c = 1; c <= 33; c++) begin
      next_edge();
      ref_enable = !(c >= 27 && c <= 31);
      u_re       = (c == 29);
      u_bank     = 2'd0;
      @(negedge clk);
      if (c >= 17) begin
        exp_addr = (c <= 27) ? 7'(c - 17) : ((c <= 32) ? 7'd10 : 7'd11);
        exp_en   = (c >= 27 && c <= 31) ? 4'b0000 : 4'b0001;
        checks++; if (sr_addr_a !== exp_addr) begin errors++; $display("FAIL en_addr cycle=%0d actual=%0d required=%0d", c, sr_addr_a, exp_addr); end
        checks++; if (ref_en_a !== exp_en) begin errors++; $display("FAIL en_ref_en cycle=%0d actual=%b required=%b", c, ref_en_a, exp_en); end
        checks++; if (stall_a !== 1'b0) begin errors++; $display("FAIL en_stall cycle=%0d actual=%b required=0", c, stall_a); end
        checks++; if (busy_a !== 1'b1) begin errors++; $display("FAIL en_busy cycle=%0d actual=%b required=1", c, busy_a); end
      end
    end
    idle_inputs();
  endtask

  task automatic test_back_to_back();
    int dones = 0;
    logic [3:0] exp_en, exp_old;
    logic [6:0] exp_addr_old;
    apply_reset();
    for (int c = 1; c <= 534; c++) begin
      next_edge();
      @(negedge clk);
      exp_en       = model_en(c);
      exp_old      = model_en(c - 1);
      exp_addr_old = model_addr(c - 1);
      if (done_a === 1'b1) dones++;
      checks++; if (ref_en_a !== exp_en) begin errors++; $display("FAIL b2b_en cycle=%0d actual=%b required=%b", c, ref_en_a, exp_en); end
      checks++; if (ref_en_old_a !== exp_old) begin errors++; $display("FAIL b2b_en_old cycle=%0d actual=%b required=%b", c, ref_en_old_a, exp_old); end
      checks++; if (sr_addr_old_a !== exp_addr_old) begin errors++; $display("FAIL b2b_addr_old cycle=%0d actual=%0d required=%0d", c, sr_addr_old_a, exp_addr_old); end
    end
    checks++; if (dones != 4) begin errors++; $display("FAIL b2b_done_count actual=%0d required=4", dones); end
  endtask

  task automatic test_reset_mid_burst();
    apply_reset();
    while (edge_n < 335) next_edge();
    @(negedge clk);
    checks++; if (sr_addr_a !== 7'd60) begin errors++; $display("FAIL mid_addr actual=%0d required=60", sr_addr_a); end
    checks++; if (ref_en_a !== 4'b0100) begin errors++; $display("FAIL mid_en actual=%b required=0100", ref_en_a); end
    checks++; if (overrun_a !== 1'b1) begin errors++; $display("FAIL mid_overrun actual=%b required=1", overrun_a); end
    #1;
    rst_n = 1'b0;
    #1;
    checks++; if (ref_en_a !== 4'b0) begin errors++; $display("FAIL arst_en actual=%b required=0000", ref_en_a); end
    checks++; if (ref_en_old_a !== 4'b0) begin errors++; $display("FAIL arst_en_old actual=%b required=0000", ref_en_old_a); end
    checks++; if (sr_addr_a !== 7'd0) begin errors++; $display("FAIL arst_addr actual=%0d required=0", sr_addr_a); end
    checks++; if (sr_addr_old_a !== 7'd0) begin errors++; $display("FAIL arst_addr_old actual=%0d required=0", sr_addr_old_a); end
    checks++; if (ind_a !== 1'b0) begin errors++; $display("FAIL arst_indicator actual=%b required=0", ind_a); end
    checks++; if (busy_a !== 1'b0) begin errors++; $display("FAIL arst_busy actual=%b required=0", busy_a); end
    checks++; if (overrun_a !== 1'b0) begin errors++; $display("FAIL arst_overrun actual=%b required=0", overrun_a); end
    checks++; if (dbg_a !== 2'(ST_IDLE)) begin errors++; $display("FAIL arst_state actual=%0d required=0", dbg_a); end
    @(posedge clk);
    #1;
    rst_n  = 1'b1;
    edge_n = 0;
    for (int c = 1; c <= 18; c++) begin
      next_edge();
      @(negedge clk);
      if (c >= 16) begin
        checks++; if (ref_en_a !== model_en(c)) begin errors++; $display("FAIL restart_en cycle=%0d actual=%b required=%b", c, ref_en_a, model_en(c)); end
        checks++; if (sr_addr_a !== model_addr(c)) begin errors++; $display("FAIL restart_addr cycle=%0d actual=%0d required=%0d", c, sr_addr_a, model_addr(c)); end
      end
    end
  endtask

  // ---------------- sequence and report ----------------
  initial begin
    rst_n = 1'b0;
    idle_inputs();
    test_reset();
    test_first_burst();
    test_collision();
    test_force();
    test_enable();
    test_back_to_back();
    test_reset_mid_burst();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
